// File: rtl/wb_stage_pkg.sv
// -----------------------------------------------------------------------------
// wb_stage_pkg
// Shared definitions for the write-back stage and any logic that needs the
// same write-back control decode (e.g. hazard detection in ID).
//   OP_RTYPE / OP_LW : opcodes that write the register file
//   REG_ZERO         : hardwired-zero register address
//   wb_ctrl_t        : decoded write-back control bundle
// Optional feature macro used by wb_stage: WB_FWD_EN (write bypass to ID).
// -----------------------------------------------------------------------------
package wb_stage_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic reg_dst;     // 1: destination is rd (inst[15:11]), 0: rt (inst[20:16])
        logic reg_wr;      // instruction writes the register file
        logic mem_to_reg;  // 1: write load data, 0: write ALU result
    } wb_ctrl_t;

    localparam wb_ctrl_t WB_CTRL_NONE = '{reg_dst: 1'b0, reg_wr: 1'b0, mem_to_reg: 1'b0};

endpackage : wb_stage_pkg

// File: rtl/wb_stage_ctrl_dec.sv
// -----------------------------------------------------------------------------
// wb_ctrl_dec
// Purely combinational opcode -> write-back control decode. Kept as its own
// module so hazard logic can instantiate the identical decode.
// Ports:
//   opcode : in  [5:0]     instruction bits [31:26]
//   ctrl   : out wb_ctrl_t {reg_dst, reg_wr, mem_to_reg}
// -----------------------------------------------------------------------------
module wb_ctrl_dec
    import wb_stage_pkg::*;
(
    input  logic [5:0] opcode,
    output wb_ctrl_t   ctrl
);

    always_comb begin
        ctrl = WB_CTRL_NONE;
        unique case (opcode)
            OP_RTYPE: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_wr     = 1'b1;
                ctrl.mem_to_reg = 1'b0;
            end
            OP_LW: begin
                ctrl.reg_dst    = 1'b0;
                ctrl.reg_wr     = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            default: ctrl = WB_CTRL_NONE;
        endcase
    end

endmodule : wb_ctrl_dec

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage
// Write-back stage: MEM/WB pipeline register plus register-file write port and
// a retired-instruction counter.
// Parameters: DATA_W (datapath width), CNT_W (retire counter width).
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   mem_valid, mem_inst,
//   mem_alu_result, mem_rdata  : instruction leaving MEM
//   wb_stall                   : hold MEM/WB contents
//   wb_flush                   : load a bubble (wins over stall)
//   rf_we, rf_waddr, rf_wdata  : register-file write port (combinational
//                                from the MEM/WB register)
//   wb_valid                   : WB holds a real instruction
//   retire_cnt                 : instructions retired since reset (wraps)
//   fwd_valid/addr/data        : previous-cycle write, for ID bypass
//                                (only when WB_FWD_EN is defined)
// Optional feature macro: WB_FWD_EN.
// -----------------------------------------------------------------------------
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_valid,
    input  logic [31:0]       mem_inst,
    input  logic [DATA_W-1:0] mem_alu_result,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              wb_stall,
    input  logic              wb_flush,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              wb_valid,
`ifdef WB_FWD_EN
    output logic              fwd_valid,
    output logic [4:0]        fwd_addr,
    output logic [DATA_W-1:0] fwd_data,
`endif
    output logic [CNT_W-1:0]  retire_cnt
);

    logic              valid_q,      valid_d;
    logic [31:0]       inst_q,       inst_d;
    logic [DATA_W-1:0] alu_result_q, alu_result_d;
    logic [DATA_W-1:0] rdata_q,      rdata_d;
    logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;
    logic              retire;
    wb_ctrl_t          ctrl;

    // ------------------------------------------------------------------
    // MEM/WB register next state: flush > stall > load
    // ------------------------------------------------------------------
    always_comb begin
        valid_d      = valid_q;
        inst_d       = inst_q;
        alu_result_d = alu_result_q;
        rdata_d      = rdata_q;
        if (wb_flush) begin
            valid_d      = 1'b0;
            inst_d       = '0;
            alu_result_d = '0;
            rdata_d      = '0;
        end else if (!wb_stall) begin
            valid_d      = mem_valid;
            inst_d       = mem_inst;
            alu_result_d = mem_alu_result;
            rdata_d      = mem_rdata;
        end
    end

    // An instruction retires when it leaves WB: either it is not held, or a
    // flush pushes it out even while a stall is requested.
    assign retire = valid_q & (~wb_stall | wb_flush);

    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (retire) begin
            retire_cnt_d = retire_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            inst_q       <= '0;
            alu_result_q <= '0;
            rdata_q      <= '0;
            retire_cnt_q <= '0;
        end else begin
            valid_q      <= valid_d;
            inst_q       <= inst_d;
            alu_result_q <= alu_result_d;
            rdata_q      <= rdata_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Write-back decode and register-file write port
    // ------------------------------------------------------------------
    wb_ctrl_dec u_ctrl_dec (
        .opcode (inst_q[31:26]),
        .ctrl   (ctrl)
    );

    assign rf_waddr   = ctrl.reg_dst ? inst_q[15:11] : inst_q[20:16];
    assign rf_wdata   = ctrl.mem_to_reg ? rdata_q : alu_result_q;
    assign rf_we      = valid_q & ctrl.reg_wr & (rf_waddr != REG_ZERO);
    assign wb_valid   = valid_q;
    assign retire_cnt = retire_cnt_q;

    // rs and funct/shamt fields are carried in the register but not needed here.
    logic unused_inst_bits;
    assign unused_inst_bits = ^{inst_q[25:21], inst_q[10:0]};

`ifdef WB_FWD_EN
    // ------------------------------------------------------------------
    // One-deep bypass of the write just performed. Captures every edge,
    // including stalls, so ID sees the write even if its RF read happened
    // before the write landed.
    // ------------------------------------------------------------------
    logic              fwd_valid_q, fwd_valid_d;
    logic [4:0]        fwd_addr_q,  fwd_addr_d;
    logic [DATA_W-1:0] fwd_data_q,  fwd_data_d;

    always_comb begin
        fwd_valid_d = rf_we & ~wb_flush;
        fwd_addr_d  = rf_waddr;
        fwd_data_d  = rf_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_valid_q <= 1'b0;
            fwd_addr_q  <= '0;
            fwd_data_q  <= '0;
        end else begin
            fwd_valid_q <= fwd_valid_d;
            fwd_addr_q  <= fwd_addr_d;
            fwd_data_q  <= fwd_data_d;
        end
    end

    assign fwd_valid = fwd_valid_q;
    assign fwd_addr  = fwd_addr_q;
    assign fwd_data  = fwd_data_q;
`endif

endmodule : wb_stage

// File: tb/tb_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_stage
// Directed-vector bench for wb_stage. Inputs change 1 time unit after the
// rising edge; outputs are checked at that same point. Define WB_FWD_EN to
// also check the bypass outputs.
// -----------------------------------------------------------------------------
module tb_wb_stage;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              mem_valid;
    logic [31:0]       mem_inst;
    logic [DATA_W-1:0] mem_alu_result;
    logic [DATA_W-1:0] mem_rdata;
    logic              wb_stall;
    logic              wb_flush;
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              wb_valid;
    logic [CNT_W-1:0]  retire_cnt;
`ifdef WB_FWD_EN
    logic              fwd_valid;
    logic [4:0]        fwd_addr;
    logic [DATA_W-1:0] fwd_data;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    wb_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_valid      (mem_valid),
        .mem_inst       (mem_inst),
        .mem_alu_result (mem_alu_result),
        .mem_rdata      (mem_rdata),
        .wb_stall       (wb_stall),
        .wb_flush       (wb_flush),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .wb_valid       (wb_valid),
`ifdef WB_FWD_EN
        .fwd_valid      (fwd_valid),
        .fwd_addr       (fwd_addr),
        .fwd_data       (fwd_data),
`endif
        .retire_cnt     (retire_cnt)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic we, input logic [4:0] waddr,
                              input logic [31:0] wdata, input logic vld, input logic [31:0] cnt);
        check_eq({tag, ".rf_we"},      64'(rf_we),      64'(we));
        check_eq({tag, ".rf_waddr"},   64'(rf_waddr),   64'(waddr));
        check_eq({tag, ".rf_wdata"},   64'(rf_wdata),   64'(wdata));
        check_eq({tag, ".wb_valid"},   64'(wb_valid),   64'(vld));
        check_eq({tag, ".retire_cnt"}, 64'(retire_cnt), 64'(cnt));
    endtask

    // Advance one cycle; with the bypass enabled, compare it to the write
    // port values seen just before the edge.
    task automatic step();
        logic           p_we;
        logic [4:0]     p_addr;
        logic [31:0]    p_data;
        logic           p_flush;
        p_we    = rf_we;
        p_addr  = rf_waddr;
        p_data  = rf_wdata;
        p_flush = wb_flush;
        @(posedge clk);
        #1;
`ifdef WB_FWD_EN
        if (rst_n) begin
            check_eq("fwd_valid", 64'(fwd_valid), 64'(p_we & ~p_flush));
            check_eq("fwd_addr",  64'(fwd_addr),  64'(p_addr));
            check_eq("fwd_data",  64'(fwd_data),  64'(p_data));
        end
`else
        p_we = p_we & ~p_flush & (p_addr != 5'd0) & (p_data != 32'd0);
`endif
    endtask

    task automatic drive(input logic v, input logic [31:0] inst,
                         input logic [31:0] alu, input logic [31:0] rd);
        mem_valid      = v;
        mem_inst       = inst;
        mem_alu_result = alu;
        mem_rdata      = rd;
    endtask

    initial begin
        // ---------------- reset with random inputs ----------------
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'($urandom), $urandom, $urandom, $urandom);
            wb_stall = 1'($urandom);
            wb_flush = 1'($urandom);
            @(posedge clk);
            #1;
            check_outs("reset", 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
        end
`ifdef WB_FWD_EN
        check_eq("reset.fwd_valid", 64'(fwd_valid), 64'd0);
`endif
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        wb_stall = 1'b0;
        wb_flush = 1'b0;
        #2 rst_n = 1'b1;
        step();
        step();
        check_outs("post_reset", 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);

        // ---------------- R-type add $8,$9,$10 ----------------
        drive(1'b1, 32'h012A4020, 32'h55, 32'h1234);
        step();
        check_outs("rtype", 1'b1, 5'd8, 32'h55, 1'b1, 32'd0);

        // ---------------- lw $11,4($8) ----------------
        drive(1'b1, 32'h8D0B0004, 32'h0000000C, 32'hDEADBEEF);
        step();
        check_outs("lw", 1'b1, 5'd11, 32'hDEADBEEF, 1'b1, 32'd1);

        // ---------------- add $0,$9,$10: no write but retires ----------------
        drive(1'b1, 32'h012A0020, 32'h77, 32'h0);
        step();
        check_outs("rd_zero", 1'b0, 5'd0, 32'h77, 1'b1, 32'd2);

        // ---------------- sw: opcode 101011, no write ----------------
        drive(1'b1, 32'hAD0B0004, 32'h0000000C, 32'hCAFEF00D);
        step();
        check_eq("sw.rf_we",      64'(rf_we),      64'd0);
        check_eq("sw.wb_valid",   64'(wb_valid),   64'd1);
        check_eq("sw.retire_cnt", 64'(retire_cnt), 64'd3);

        // ---------------- 3-cycle stall on add $12,$10,$11 ----------------
        drive(1'b1, 32'h014B6020, 32'h99, 32'h0);
        step();
        check_outs("pre_stall", 1'b1, 5'd12, 32'h99, 1'b1, 32'd4);
        wb_stall = 1'b1;
        drive(1'b1, 32'h8D0B0004, 32'hAAAA, 32'hBBBB);
        for (int i = 0; i < 3; i++) begin
            step();
            check_outs("stall", 1'b1, 5'd12, 32'h99, 1'b1, 32'd4);
        end
        wb_stall = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        step();
        check_outs("stall_release", 1'b0, 5'd0, 32'h0, 1'b0, 32'd5);

        // ---------------- flush together with stall ----------------
        drive(1'b1, 32'h012A4020, 32'h11, 32'h0);
        step();
        check_outs("pre_flush", 1'b1, 5'd8, 32'h11, 1'b1, 32'd5);
        wb_stall = 1'b1;
        wb_flush = 1'b1;
        step();
        // held instruction is pushed out by the flush and counts as retired
        check_outs("flush_stall", 1'b0, 5'd0, 32'h0, 1'b0, 32'd6);

        // ---------------- flush on an empty stage ----------------
        wb_stall = 1'b0;
        step();
        check_outs("flush_empty", 1'b0, 5'd0, 32'h0, 1'b0, 32'd6);
        wb_flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        step();
        check_eq("idle.retire_cnt", 64'(retire_cnt), 64'd6);

        // ---------------- counter wrap ----------------
        force dut.retire_cnt_q = 32'hFFFFFFFF;
        #1;
        release dut.retire_cnt_q;
        #1;
        check_eq("preset.retire_cnt", 64'(retire_cnt), 64'hFFFFFFFF);
        drive(1'b1, 32'h014B6020, 32'h42, 32'h0);
        step();
        check_eq("wrap_in.retire_cnt", 64'(retire_cnt), 64'hFFFFFFFF);
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        step();
        check_eq("wrap.retire_cnt", 64'(retire_cnt), 64'd0);

        // ---------------- asynchronous reset mid-operation ----------------
        drive(1'b1, 32'h8D0B0004, 32'h0, 32'h13579BDF);
        step();
        check_outs("pre_areset", 1'b1, 5'd11, 32'h13579BDF, 1'b1, 32'd0);
        rst_n = 1'b0;
        #1;
        check_outs("areset", 1'b0, 5'd0, 32'h0, 1'b0, 32'd0);
        #1 rst_n = 1'b1;
        step();
        check_outs("first_capture", 1'b1, 5'd11, 32'h13579BDF, 1'b1, 32'd0);
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        step();
        check_outs("final", 1'b0, 5'd0, 32'h0, 1'b0, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_wb_stage
